raster_stamp_arb: RTL

- Merges raster stamp streams from NUM_INPUTS raster slices onto a single stamp output.
- Each stamp is a packed quad record: pos_x, pos_y, 4-bit mask, bcoord_x/y/z and pid.
- Grants one requester per cycle using round-robin and registers the winner into a one-entry output stage.
- Aggregates the slices' completion flags into one done signal.
- Sits between the raster slices and the raster-to-core CSR/request path.

---
 rtl/raster_stamp_arb_pkg.sv | 33 +++
 rtl/raster_stamp_arb_rr_arbiter.sv | 63 ++++++
 rtl/raster_stamp_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/raster_stamp_arb_pkg.sv
// Shared raster types for the stamp arbiter and its round-robin sub-arbiter.
// Contents:
//   raster_stamp_t        - packed quad record (position, coverage mask, barycentrics, pid)
//   STAMP_W               - width of one packed stamp
//   RASTER_ARB_MAX_INPUTS - largest slice count the arbiter supports
//   raster_arb_perf_t     - perf counter bundle (used when RASTER_ARB_PERF_EN is defined)
//   rr_idx_w()            - index width for an N-way arbiter (at least 1 bit)
package raster_stamp_arb_pkg;

    localparam int unsigned RASTER_ARB_MAX_INPUTS = 16;

    typedef struct packed {
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [3:0]  mask;
        logic [31:0] bcoord_x;
        logic [31:0] bcoord_y;
        logic [31:0] bcoord_z;
        logic [7:0]  pid;
    } raster_stamp_t;

    localparam int unsigned STAMP_W = $bits(raster_stamp_t);

    typedef struct packed {
        logic [43:0]                                stall_cycles;
        logic [RASTER_ARB_MAX_INPUTS-1:0][31:0]     grants;
    } raster_arb_perf_t;

    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_stamp_arb_rr_arbiter.sv
// raster_rr_arbiter: generic NUM_REQS-way round-robin arbiter.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (pointer returns to 0)
//   req          - request vector
//   advance      - the current grant completed a transfer; rotate priority past it
//   grant        - one-hot grant (zero when no request)
//   grant_idx    - binary index of the grant
//   grant_valid  - at least one request is granted
module raster_rr_arbiter
    import raster_stamp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    localparam int unsigned IDX_W   = rr_idx_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    // One extra bit so ptr + offset never overflows before the modulo fold.
    logic [IDX_W:0]   cand;

    // Search upward from the pointer, wrapping modulo NUM_REQS; first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_REQS; off++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(NUM_REQS)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQS);
            end
            if (!grant_valid && req[cand[IDX_W-1:0]]) begin
                grant[cand[IDX_W-1:0]] = 1'b1;
                grant_idx              = cand[IDX_W-1:0];
                grant_valid            = 1'b1;
            end
        end
    end

    // A stalled grant leaves the pointer alone; only a completed transfer rotates it.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/raster_stamp_arb.sv
// raster_stamp_arb: merges NUM_INPUTS raster slice stamp streams onto one output.
// Round-robin grant per cycle, optional one-entry registered output stage,
// and aggregation of slice completion into a single done flag.
// Optional feature macro: RASTER_ARB_PERF_EN (adds stall and per-input grant counters).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   valid_in/stamp_in   - per-slice stamp handshake (held until accepted)
//   done_in             - per-slice "all stamps emitted" level
//   ready_in            - per-slice accept, one-hot or zero
//   valid_out/stamp_out - merged stamp, held until ready_out
//   done_out            - all slices done and nothing pending (registered)
//   ready_out           - downstream accept
//   perf_stall_cycles   - (RASTER_ARB_PERF_EN) cycles with valid_out && !ready_out
//   perf_grants         - (RASTER_ARB_PERF_EN) per-input accepted stamp count
module raster_stamp_arb
    import raster_stamp_arb_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_INPUTS-1:0]               valid_in,
    input  logic [NUM_INPUTS-1:0][STAMP_W-1:0]  stamp_in,
    input  logic [NUM_INPUTS-1:0]               done_in,
    output logic [NUM_INPUTS-1:0]               ready_in,
    output logic                                valid_out,
    output logic [STAMP_W-1:0]                  stamp_out,
    output logic                                done_out,
    input  logic                                ready_out
`ifdef RASTER_ARB_PERF_EN
    ,
    output logic [43:0]                         perf_stall_cycles,
    output logic [NUM_INPUTS-1:0][31:0]         perf_grants
`endif
);

    localparam int unsigned IDX_W = rr_idx_w(NUM_INPUTS);

    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  any_valid;
    logic [NUM_INPUTS-1:0] ready_raw;
    logic                  xfer_in;
    logic                  done_q;

    assign xfer_in = |(valid_in & ready_in);

    raster_rr_arbiter #(
        .NUM_REQS (NUM_INPUTS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (valid_in),
        .advance     (xfer_in),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (any_valid)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic               valid_q;
        logic [STAMP_W-1:0] stamp_q;
        logic               stage_can_accept;

        assign stage_can_accept = !valid_q || ready_out;
        assign ready_raw        = grant & {NUM_INPUTS{stage_can_accept}};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                stamp_q <= '0;
            end else if (xfer_in) begin
                valid_q <= 1'b1;
                stamp_q <= stamp_in[grant_idx];
            end else if (ready_out) begin
                valid_q <= 1'b0;
            end
        end

        assign valid_out = valid_q;
        assign stamp_out = stamp_q;
    end else begin : g_out_pass
        assign ready_raw = grant & {NUM_INPUTS{ready_out}};
        // Gated so reset forces the reset values even though the path is combinational.
        assign valid_out = !reset && any_valid;
        assign stamp_out = reset ? '0 : stamp_in[grant_idx];
    end

    // The registered stage can accept while its own flop is held in reset; mask it.
    assign ready_in = reset ? '0 : ready_raw;

    // Requiring the stage to be empty or draining keeps done behind the last stamp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (&done_in) && !(|valid_in) && (!valid_out || ready_out);
        end
    end

    assign done_out = done_q;

`ifdef RASTER_ARB_PERF_EN
    logic [43:0]                 stall_q;
    logic [NUM_INPUTS-1:0][31:0] grants_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            grants_q <= '0;
        end else begin
            if (valid_out && !ready_out) begin
                stall_q <= stall_q + 44'd1;
            end
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (valid_in[i] && ready_in[i]) begin
                    grants_q[i] <= grants_q[i] + 32'd1;
                end
            end
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_grants       = grants_q;
`endif

endmodule
